// File: rtl/ntt_bfu_pkg.sv
// Shared Kyber constants and butterfly mode encoding for the NTT butterfly unit.
package kyber_pkg;

    localparam int KYBER_Q    = 3329;
    localparam int KYBER_QINV = -3327;
    localparam int BARRETT_V  = 20159;
    localparam int BFU_LAT    = 4;

    typedef enum logic {
        CT = 1'b0,
        GS = 1'b1
    } bfu_mode_e;

endpackage

// File: rtl/ntt_bfu_if.sv
// Valid/ready input and output beats of the butterfly unit, all lanes packed side by side.
interface ntt_bfu_if #(
    parameter int LANES = 2,
    parameter int TAG_W = 8
);

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [16*LANES-1:0]   in_a;
    logic [16*LANES-1:0]   in_b;
    logic [16*LANES-1:0]   in_zeta;
    logic [TAG_W-1:0]      in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mode;
    logic [16*LANES-1:0]   out_a;
    logic [16*LANES-1:0]   out_b;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_zeta, in_tag, out_ready,
        input  in_ready, out_valid, out_mode, out_a, out_b, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_zeta, in_tag, out_ready,
        output in_ready, out_valid, out_mode, out_a, out_b, out_tag
    );

endinterface

// File: rtl/ntt_bfu_lane.sv
// One lane of the CT/GS butterfly: 4 register stages, Montgomery multiply and Barrett reduce.
module ntt_bfu_lane
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               set,
    input  logic               en,
    input  bfu_mode_e          mode_s1,
    input  bfu_mode_e          mode_s2,
    input  bfu_mode_e          mode_s3,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic signed [15:0] zeta,
    output logic signed [15:0] ra,
    output logic signed [15:0] rb
);

    localparam int BARRETT_RND = 1 << 25;

    logic signed [15:0] a1, b1, z1, sum1, diff1;
    logic signed [31:0] prod2, bar2;
    logic signed [15:0] add2;
    logic signed [31:0] prod3;
    logic signed [15:0] u3, add3;

    logic signed [15:0] mul_x, add_n, u_n, bred_n, fq_n;
    logic signed [31:0] prod_n, bar_n;

    assign mul_x  = (mode_s1 == GS) ? diff1 : b1;
    assign add_n  = (mode_s1 == GS) ? sum1 : a1;
    assign prod_n = 32'(mul_x) * 32'(z1);
    // Barrett: the 20159*v multiply lands in stage 2, the quotient correction in stage 3
    assign bar_n  = BARRETT_V * 32'(sum1) + BARRETT_RND;
    assign bred_n = 16'(32'(add2) - KYBER_Q * (bar2 >>> 26));
    assign u_n    = 16'($signed(prod2[15:0]) * 16'(KYBER_QINV));
    assign fq_n   = 16'((prod3 - 32'(u3) * KYBER_Q) >>> 16);

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            a1    <= '0;
            b1    <= '0;
            z1    <= '0;
            sum1  <= '0;
            diff1 <= '0;
            prod2 <= '0;
            bar2  <= '0;
            add2  <= '0;
            prod3 <= '0;
            u3    <= '0;
            add3  <= '0;
            ra    <= '0;
            rb    <= '0;
        end else if (en) begin
            a1    <= a;
            b1    <= b;
            z1    <= zeta;
            sum1  <= a + b;
            diff1 <= b - a;
            prod2 <= prod_n;
            bar2  <= bar_n;
            add2  <= add_n;
            prod3 <= prod2;
            u3    <= u_n;
            add3  <= (mode_s2 == GS) ? bred_n : add2;
            ra    <= (mode_s3 == GS) ? add3 : add3 + fq_n;
            rb    <= (mode_s3 == GS) ? fq_n : add3 - fq_n;
        end
    end

endmodule

// File: rtl/ntt_bfu.sv
// Multi-lane NTT butterfly unit: owns the valid/stall/tag/mode pipeline shared by all lanes.
module ntt_bfu
    import kyber_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 8
) (
    input  logic     clk,
    input  logic     set,
    ntt_bfu_if.slave bus
);

    logic                            en;
    logic [BFU_LAT-1:0]              vld;
    logic [BFU_LAT-1:0]              mode_q;
    logic [BFU_LAT-1:0][TAG_W-1:0]   tag_q;

    // The whole pipe advances together; a stalled output freezes every stage
    assign en            = bus.out_ready || !vld[BFU_LAT-1];
    assign bus.in_ready  = en;
    assign bus.out_valid = vld[BFU_LAT-1];
    assign bus.out_mode  = mode_q[BFU_LAT-1];
    assign bus.out_tag   = tag_q[BFU_LAT-1];

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            vld    <= '0;
            mode_q <= '0;
            tag_q  <= '0;
        end else if (en) begin
            vld    <= {vld[BFU_LAT-2:0], bus.in_valid};
            mode_q <= {mode_q[BFU_LAT-2:0], bus.in_mode};
            tag_q  <= {tag_q[BFU_LAT-2:0], bus.in_tag};
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ntt_bfu_lane u_lane (
            .clk     (clk),
            .set     (set),
            .en      (en),
            .mode_s1 (bfu_mode_e'(mode_q[0])),
            .mode_s2 (bfu_mode_e'(mode_q[1])),
            .mode_s3 (bfu_mode_e'(mode_q[2])),
            .a       (bus.in_a[16*k +: 16]),
            .b       (bus.in_b[16*k +: 16]),
            .zeta    (bus.in_zeta[16*k +: 16]),
            .ra      (bus.out_a[16*k +: 16]),
            .rb      (bus.out_b[16*k +: 16])
        );
    end

endmodule

// File: tb/tb_ntt_bfu.sv
// Bench for ntt_bfu: directed table, mixed-mode stream, stall, reset and random runs on 1/2/4 lanes.
module tb_ntt_bfu;

    logic        clk = 1'b0;
    logic        set;
    logic        in_valid, in_mode, out_ready;
    logic [63:0] in_a, in_b, in_zeta;
    logic [7:0]  in_tag;

    always #5 clk = ~clk;

    ntt_bfu_if #(.LANES(1), .TAG_W(8)) if1 ();
    ntt_bfu_if #(.LANES(2), .TAG_W(8)) if2 ();
    ntt_bfu_if #(.LANES(4), .TAG_W(8)) if4 ();

    assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;  assign if4.in_valid = in_valid;
    assign if1.in_mode  = in_mode;   assign if2.in_mode  = in_mode;   assign if4.in_mode  = in_mode;
    assign if1.in_tag   = in_tag;    assign if2.in_tag   = in_tag;    assign if4.in_tag   = in_tag;
    assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;
    assign if1.in_a    = in_a[15:0];    assign if2.in_a    = in_a[31:0];    assign if4.in_a    = in_a;
    assign if1.in_b    = in_b[15:0];    assign if2.in_b    = in_b[31:0];    assign if4.in_b    = in_b;
    assign if1.in_zeta = in_zeta[15:0]; assign if2.in_zeta = in_zeta[31:0]; assign if4.in_zeta = in_zeta;

    ntt_bfu #(.LANES(1), .TAG_W(8)) dut1 (.clk(clk), .set(set), .bus(if1));
    ntt_bfu #(.LANES(2), .TAG_W(8)) dut2 (.clk(clk), .set(set), .bus(if2));
    ntt_bfu #(.LANES(4), .TAG_W(8)) dut4 (.clk(clk), .set(set), .bus(if4));

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int wrap16(input int v);
        int t;
        t = v & 32'hFFFF;
        return (t >= 32768) ? t - 65536 : t;
    endfunction

    function automatic int fqmul(input int x, input int z);
        int p, u;
        p = x * z;
        u = wrap16(wrap16(p) * -3327);
        return wrap16((p - u * 3329) >>> 16);
    endfunction

    function automatic int barrett(input int v);
        int w, t;
        w = wrap16(v);
        t = (20159 * w + (1 << 25)) >>> 26;
        return wrap16(w - 3329 * t);
    endfunction

    function automatic void bfly(input logic mode, input int a, input int b, input int z,
                                 output int ra, output int rb);
        int t;
        if (mode == 1'b0) begin
            t  = fqmul(b, z);
            ra = wrap16(a + t);
            rb = wrap16(a - t);
        end else begin
            ra = barrett(a + b);
            rb = fqmul(wrap16(b - a), z);
        end
    endfunction

    function automatic int lane(input logic [63:0] v, input int k);
        logic [15:0] s;
        s = v[16*k +: 16];
        return int'($signed(s));
    endfunction

    // ---------------- bookkeeping ----------------
    typedef struct {
        int         ea[4];
        int         eb[4];
        logic [7:0] tag;
        logic       mode;
    } exp_t;

    typedef struct {
        logic mode;
        int   a, b, z;
        int   ea, eb;
    } vec_t;

    exp_t        q[$];
    exp_t        cur;
    bit          pend;
    int          npass = 0, nchk = 0;
    int          gen_cnt = 0, pop_cnt = 0, cyc = 0;
    int          first_out, last_out;
    int          pol;
    bit          snap_ok;
    logic [31:0] snap_a, snap_b;
    logic [7:0]  snap_tag;
    logic        snap_mode;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic int pick();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -3328;
        if (r == 1) return 3328;
        return int'($urandom_range(0, 6656)) - 3328;
    endfunction

    task automatic gen_beat();
        int a, b, z, ra, rb;
        cur.mode = (pol == 0) ? logic'(gen_cnt % 2) : logic'($urandom_range(0, 1));
        cur.tag  = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            a = pick(); b = pick(); z = pick();
            in_a[16*k +: 16]    = 16'(a);
            in_b[16*k +: 16]    = 16'(b);
            in_zeta[16*k +: 16] = 16'(z);
            bfly(cur.mode, a, b, z, ra, rb);
            cur.ea[k] = ra;
            cur.eb[k] = rb;
        end
        in_mode = cur.mode;
        in_tag  = cur.tag;
        pend    = 1'b1;
        gen_cnt++;
    endtask

    task automatic check_head();
        exp_t e;
        if (q.size() == 0) begin
            chk("out_valid_unexpected", int'(if2.out_valid), 0);
            return;
        end
        e = q.pop_front();
        pop_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("l2.out_a[%0d]", k), lane(64'(if2.out_a), k), e.ea[k]);
            chk($sformatf("l2.out_b[%0d]", k), lane(64'(if2.out_b), k), e.eb[k]);
        end
        chk("l2.out_tag", int'(if2.out_tag), int'(e.tag));
        chk("l2.out_mode", int'(if2.out_mode), int'(e.mode));
        chk("l1.out_valid", int'(if1.out_valid), 1);
        chk("l1.out_a[0]", lane(64'(if1.out_a), 0), e.ea[0]);
        chk("l1.out_b[0]", lane(64'(if1.out_b), 0), e.eb[0]);
        chk("l4.out_valid", int'(if4.out_valid), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("l4.out_a[%0d]", k), lane(if4.out_a, k), e.ea[k]);
            chk($sformatf("l4.out_b[%0d]", k), lane(if4.out_b, k), e.eb[k]);
        end
    endtask

    // One clock cycle: drive, settle, check the output side, record acceptance, advance.
    task automatic step(input bit want, input bit ordy);
        out_ready = ordy;
        if (want && !pend) gen_beat();
        in_valid = want && pend;
        #1;
        if (if2.out_valid) begin
            if (ordy) begin
                snap_ok = 1'b0;
                check_head();
            end else begin
                chk("in_ready_stall", int'(if2.in_ready), 0);
                if (snap_ok) begin
                    chk("hold_out_a", int'(if2.out_a == snap_a), 1);
                    chk("hold_out_b", int'(if2.out_b == snap_b), 1);
                    chk("hold_tag_mode", int'({if2.out_tag, if2.out_mode}), int'({snap_tag, snap_mode}));
                end
                snap_ok = 1'b1;
                snap_a = if2.out_a; snap_b = if2.out_b;
                snap_tag = if2.out_tag; snap_mode = if2.out_mode;
            end
        end
        if (in_valid && if2.in_ready) begin
            q.push_back(cur);
            pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            step(1'b0, 1'b1);
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        logic [7:0] tg;
        tg = 8'h5A ^ 8'(idx);
        out_ready = 1'b1;
        in_mode   = v.mode;
        in_tag    = tg;
        for (int k = 0; k < 4; k++) begin
            in_a[16*k +: 16]    = 16'(v.a);
            in_b[16*k +: 16]    = 16'(v.b);
            in_zeta[16*k +: 16] = 16'(v.z);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!if2.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("vec%0d.latency", idx), n, 4);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("vec%0d.out_a[%0d]", idx, k), lane(64'(if2.out_a), k), v.ea);
            chk($sformatf("vec%0d.out_b[%0d]", idx, k), lane(64'(if2.out_b), k), v.eb);
        end
        chk($sformatf("vec%0d.tag", idx), int'(if2.out_tag), int'(tg));
        chk($sformatf("vec%0d.mode", idx), int'(if2.out_mode), int'(v.mode));
        @(posedge clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        int p0, g0;

        // mode, a, b, zeta, expected out_a, expected out_b (lane values, 16-bit signed)
        vt[0] = '{1'b0,   500,   100, 2285,    600,    400};
        vt[1] = '{1'b1,   500,   100, 2285,    600,   -400};
        vt[2] = '{1'b1,  3000,  3000, 2285,   -658,      0};
        vt[3] = '{1'b0, -3328,  3328, 2285,  -3329,  -3327};
        vt[4] = '{1'b0, 32767,   100, 2285, -32669,  32667};
        vt[5] = '{1'b1,     0,     1,    1,      1,    169};

        set = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_zeta = '0; in_tag = '0;
        pend = 1'b0; snap_ok = 1'b0; first_out = -1; pol = 1;
        snap_a = '0; snap_b = '0; snap_tag = '0; snap_mode = 1'b0;

        #2;
        chk("rst.out_valid", int'(if2.out_valid), 0);
        chk("rst.in_ready", int'(if2.in_ready), 1);
        chk("rst.out_a", int'(if2.out_a), 0);
        chk("rst.out_b", int'(if2.out_b), 0);
        chk("rst.out_tag", int'(if2.out_tag), 0);
        chk("rst.out_mode", int'(if2.out_mode), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        set = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // 16 back-to-back beats of alternating mode
        pol = 0; first_out = -1; p0 = pop_cnt;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
        drain();
        chk("stream_count", pop_cnt - p0, 16);
        chk("stream_run", last_out - first_out + 1, 16);

        // full pipe, downstream stalls for 3 cycles
        pol = 1; p0 = pop_cnt; g0 = gen_cnt;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        drain();
        chk("stall_count", pop_cnt - p0, gen_cnt - g0);

        // reset with 3 beats in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        set = 1'b0;
        #1;
        chk("midrst.out_valid.l1", int'(if1.out_valid), 0);
        chk("midrst.out_valid.l2", int'(if2.out_valid), 0);
        chk("midrst.out_valid.l4", int'(if4.out_valid), 0);
        chk("midrst.in_ready", int'(if2.in_ready), 1);
        chk("midrst.out_a", int'(if2.out_a), 0);
        @(posedge clk);
        #1;
        set = 1'b1;
        q.delete();
        pend = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        drain();

        // random traffic and backpressure across 1/2/4 lane instances
        pol = 1;
        for (int i = 0; i < 120; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7);
        drain();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
